// File: rtl/text_overlay_ctrl.sv
// Text-overlay sequencer: character buffer, char_ROM addressing, glyph-bit select and
// sync delay, plus a host write port and a buffer-clear sweep.
module text_overlay_ctrl #(
   parameter int COLS = 16,
   parameter int ROWS = 4,
   parameter int X0   = 0,
   parameter int Y0   = 0,
   parameter int HW   = 11,
   parameter int AW   = $clog2(COLS * ROWS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [HW-1:0] hcount,
   input  logic [HW-1:0] vcount,
   input  logic          de_in,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          clr_req,
   output logic          wr_ack,
   output logic          busy,
   output logic [7:0]    rom_addr,
   input  logic [63:0]   rom_dout,
   output logic          pix_on,
   output logic          de_out,
   output logic          hs_out,
   output logic          vs_out
);
   localparam int CELLS = COLS * ROWS;
   localparam logic [HW:0]   X_LO   = (HW+1)'(X0);
   localparam logic [HW:0]   Y_LO   = (HW+1)'(Y0);
   localparam logic [HW:0]   X_SPAN = (HW+1)'(8 * COLS);
   localparam logic [HW:0]   Y_SPAN = (HW+1)'(8 * ROWS);
   localparam logic [AW-1:0] LAST   = AW'(CELLS - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   logic [7:0]    mem_r [CELLS];
   state_t        state_r;
   logic [AW-1:0] ptr_r;

   logic [HW:0]   dx_s, dy_s;
   logic          in_win_s, host_acc_s, we_s;
   logic [AW-1:0] rd_addr_s, wa_s;
   logic [7:0]    wd_s;

   logic [AW-1:0] rd_addr_r;
   logic          en1_r, en2_r, en3_r;
   logic [2:0]    r1_r, c1_r, r2_r, c2_r, r3_r, c3_r;
   logic [2:0]    sync1_r, sync2_r, sync3_r;

   // Offsets are taken one bit wider so a coordinate left of/above the window wraps far out of range.
   assign dx_s      = {1'b0, hcount} - X_LO;
   assign dy_s      = {1'b0, vcount} - Y_LO;
   assign in_win_s  = (dx_s < X_SPAN) && (dy_s < Y_SPAN);
   assign rd_addr_s = AW'(int'(dy_s[HW-1:3]) * COLS + int'(dx_s[HW-1:3]));

   // Write-port arbitration: the clear sweep owns the port; host writes only when idle and no clear pending.
   always_comb begin
      host_acc_s = 1'b0;
      we_s       = 1'b0;
      wa_s       = wr_addr;
      wd_s       = wr_data;
      if (state_r == CLEAR) begin
         we_s = 1'b1;
         wa_s = ptr_r;
         wd_s = 8'h00;
      end else begin
         host_acc_s = wr_en & ~clr_req & (int'(wr_addr) < CELLS);
         we_s       = host_acc_s;
      end
   end

   // Character buffer write port.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[wa_s] <= wd_s;
      end
   end

   // Clear sequencer with registered busy and write acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CLEAR;
         ptr_r   <= {AW{1'b0}};
         busy    <= 1'b1;
         wr_ack  <= 1'b0;
      end else begin
         wr_ack <= host_acc_s;
         case (state_r)
            CLEAR: begin
               if (ptr_r == LAST) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  ptr_r   <= {AW{1'b0}};
               end else begin
                  ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state_r <= CLEAR;
                  busy    <= 1'b1;
                  ptr_r   <= {AW{1'b0}};
               end
            end
            default: begin
               state_r <= CLEAR;
               busy    <= 1'b1;
               ptr_r   <= {AW{1'b0}};
            end
         endcase
      end
   end

   // Display pipeline: coords -> buffer read -> char_ROM -> glyph bit; syncs ride along as {de,hs,vs}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_r <= {AW{1'b0}};
         en1_r     <= 1'b0;
         en2_r     <= 1'b0;
         en3_r     <= 1'b0;
         r1_r      <= 3'd0;
         c1_r      <= 3'd0;
         r2_r      <= 3'd0;
         c2_r      <= 3'd0;
         r3_r      <= 3'd0;
         c3_r      <= 3'd0;
         sync1_r   <= 3'd0;
         sync2_r   <= 3'd0;
         sync3_r   <= 3'd0;
         rom_addr  <= 8'h00;
         pix_on    <= 1'b0;
         de_out    <= 1'b0;
         hs_out    <= 1'b0;
         vs_out    <= 1'b0;
      end else begin
         rd_addr_r <= (in_win_s & de_in) ? rd_addr_s : {AW{1'b0}};
         en1_r     <= in_win_s & de_in;
         r1_r      <= dy_s[2:0];
         c1_r      <= dx_s[2:0];
         sync1_r   <= {de_in, hs_in, vs_in};
         rom_addr  <= en1_r ? mem_r[rd_addr_r] : 8'h00;
         en2_r     <= en1_r;
         r2_r      <= r1_r;
         c2_r      <= c1_r;
         sync2_r   <= sync1_r;
         en3_r     <= en2_r;
         r3_r      <= r2_r;
         c3_r      <= c2_r;
         sync3_r   <= sync2_r;
         // Bit 63-8r-c is simply {~r,~c}.
         pix_on    <= en3_r & rom_dout[{~r3_r, ~c3_r}];
         {de_out, hs_out, vs_out} <= sync3_r;
      end
   end
endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Bench for text_overlay_ctrl: char_ROM model, cell-level reference model checked every
// cycle, directed probes from the test plan and a randomized traffic phase.
module tb_text_overlay_ctrl;
   localparam int COLS = 16, ROWS = 4, X0 = 0, Y0 = 0, HW = 11, AW = 6;
   localparam int CELLS = COLS * ROWS;

   logic          clk = 1'b0, rst_n = 1'b1;
   logic [HW-1:0] hcount = '0, vcount = '0;
   logic          de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
   logic          wr_en = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          wr_ack, busy, pix_on, de_out, hs_out, vs_out;
   logic [7:0]    rom_addr;
   logic [63:0]   rom_dout = 64'd0;

   int n_chk = 0, n_fail = 0;

   // reference model state
   logic [7:0] mbuf [CELLS];
   int         sweep_left;
   logic       exp_busy, exp_ack;
   logic [7:0] h_code [4];
   logic [3:0] h_pix, h_de, h_hs, h_vs;
   logic       any_pix, any_ack, any_nz;
   logic [19:0] pat_hs, pat_vs, pat_de;

   text_overlay_ctrl #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .HW(HW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
      .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
      .wr_ack(wr_ack), .busy(busy), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .pix_on(pix_on), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] glyph(input logic [7:0] code);
      case (code)
         8'h00:   glyph = 64'h0;
         8'h16:   glyph = 64'h18381818_18187E00;
         8'h1C:   glyph = 64'h3C66667E_66666600;
         default: glyph = {code, code ^ 8'h5A, ~code, code ^ 8'hC3,
                           code ^ 8'h0F, code ^ 8'h99, ~(code ^ 8'h33), code ^ 8'h66};
      endcase
   endfunction

   // char_ROM: one-cycle registered lookup
   always @(posedge clk) rom_dout <= glyph(rom_addr);

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic m_reset();
      sweep_left = CELLS;
      exp_busy   = 1'b1;
      exp_ack    = 1'b0;
      for (int i = 0; i < 4; i++) h_code[i] = 8'h00;
      h_pix = 4'd0; h_de = 4'd0; h_hs = 4'd0; h_vs = 4'd0;
   endtask

   task automatic m_step();
      logic [7:0]  code;
      logic        p;
      logic [63:0] g;
      int          dx, dy;
      exp_ack = 1'b0;
      if (sweep_left > 0) begin
         mbuf[CELLS - sweep_left] = 8'h00;
         sweep_left--;
      end else if (clr_req) begin
         sweep_left = CELLS;
      end else if (wr_en && int'(wr_addr) < CELLS) begin
         mbuf[wr_addr] = wr_data;
         exp_ack = 1'b1;
      end
      exp_busy = (sweep_left > 0);
      dx = int'(hcount) - X0;
      dy = int'(vcount) - Y0;
      code = 8'h00;
      p = 1'b0;
      if (de_in && dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 8 * ROWS) begin
         code = mbuf[(dy / 8) * COLS + dx / 8];
         g = glyph(code);
         p = g[63 - 8 * (dy % 8) - dx % 8];
      end
      for (int i = 3; i > 0; i--) h_code[i] = h_code[i-1];
      h_code[0] = code;
      h_pix = {h_pix[2:0], p};
      h_de  = {h_de[2:0], de_in};
      h_hs  = {h_hs[2:0], hs_in};
      h_vs  = {h_vs[2:0], vs_in};
   endtask

   // model advances on every clock edge and on reset assertion
   initial begin
      for (int i = 0; i < CELLS; i++) mbuf[i] = 8'h00;
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // compare process: every output, every cycle
   initial begin
      forever begin
         @(negedge clk);
         chk("rom_addr", int'(rom_addr), int'(h_code[1]));
         chk("pix_on",   int'(pix_on),   int'(h_pix[3]));
         chk("de_out",   int'(de_out),   int'(h_de[3]));
         chk("hs_out",   int'(hs_out),   int'(h_hs[3]));
         chk("vs_out",   int'(vs_out),   int'(h_vs[3]));
         chk("busy",     int'(busy),     int'(exp_busy));
         chk("wr_ack",   int'(wr_ack),   int'(exp_ack));
      end
   end

   task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d, input logic ack_v, input string nm);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      chk(nm, int'(wr_ack), int'(ack_v));
   endtask

   task automatic probe(input int h, input int v, input int code, input int pix, input string nm);
      hcount = HW'(h); vcount = HW'(v); de_in = 1'b1;
      @(negedge clk);
      de_in = 1'b0; hcount = HW'(200);
      @(negedge clk);
      chk({nm, "_rom"}, int'(rom_addr), code);
      repeat (2) @(negedge clk);
      if (pix >= 0) chk({nm, "_pix"}, int'(pix_on), pix);
   endtask

   task automatic busy_len(input string nm);
      int n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk(nm, n, 64);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 1);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_ack", int'(wr_ack), 0);
      chk("rst_pix", int'(pix_on), 0);
      rst_n = 1'b1;
      busy_len("init_busy_len");

      // full window scan of the cleared buffer
      any_pix = 1'b0; any_ack = 1'b0; de_in = 1'b1;
      for (int v = 0; v < 8 * ROWS; v++) begin
         for (int h = 0; h < 8 * COLS; h++) begin
            hcount = HW'(X0 + h); vcount = HW'(Y0 + v);
            @(negedge clk);
            any_pix |= pix_on; any_ack |= wr_ack;
         end
      end
      de_in = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any_pix |= pix_on;
      end
      chk("scan_blank_pix", int'(any_pix), 0);
      chk("scan_no_ack", int'(any_ack), 0);

      host_write(6'd0, 8'h16, 1'b1, "ack_wr0");
      probe(X0 + 3, Y0, 8'h16, 1, "one_c3");
      probe(X0, Y0, 8'h16, 0, "one_c0");
      host_write(6'd17, 8'h1C, 1'b1, "ack_wr17");
      probe(X0 + 9, Y0 + 10, 8'h1C, 1, "A_c1");
      probe(X0 + 11, Y0 + 10, 8'h1C, 0, "A_c3");
      host_write(6'd63, 8'h2A, 1'b1, "ack_wr63");
      probe(X0 + 127, Y0 + 31, 8'h2A, 0, "last_cell");
      probe(X0 + 128, Y0 + 31, 0, 0, "x_edge");
      probe(X0 + 127, Y0 + 32, 0, 0, "y_edge");

      // write colliding with clear, then write during busy
      wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h77; clr_req = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; clr_req = 1'b0;
      chk("clr_wr_ack", int'(wr_ack), 0);
      chk("clr_busy", int'(busy), 1);
      host_write(6'd6, 8'h33, 1'b0, "busy_wr_ack");
      wait_idle();
      probe(X0 + 3, Y0, 0, 0, "cleared_c0");
      probe(X0 + 41, Y0, 0, 0, "dropped_wr");

      // sync pass-through, outside the window
      pat_hs = 20'b0011_1100_0000_1111_0010;
      pat_vs = 20'b1000_0001_1111_0000_0110;
      pat_de = 20'b0110_1011_0010_1101_1001;
      hcount = HW'(200);
      for (int i = 0; i < 20; i++) begin
         hs_in = pat_hs[i]; vs_in = pat_vs[i]; de_in = pat_de[i];
         @(negedge clk);
         if (i >= 3) begin
            chk("pat_hs", int'(hs_out), int'(pat_hs[i-3]));
            chk("pat_vs", int'(vs_out), int'(pat_vs[i-3]));
            chk("pat_de", int'(de_out), int'(pat_de[i-3]));
         end
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         hcount  = HW'($urandom_range(0, 140));
         vcount  = HW'($urandom_range(0, 40));
         de_in   = ($urandom_range(0, 3) != 0);
         hs_in   = 1'($urandom_range(0, 1));
         vs_in   = 1'($urandom_range(0, 1));
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_addr = AW'($urandom_range(0, CELLS - 1));
         wr_data = 8'($urandom_range(1, 255));
         clr_req = ($urandom_range(0, 399) == 0);
         @(negedge clk);
      end
      wr_en = 1'b0; clr_req = 1'b0; de_in = 1'b0; vs_in = 1'b0;
      wait_idle();
      // refill so the interrupted sweep has real content to clear
      for (int i = 0; i < CELLS; i++) host_write(AW'(i), 8'(i + 1), 1'b1, "refill_ack");

      // reset in the middle of a clear sweep
      hs_in = 1'b1; de_in = 1'b1; hcount = HW'(200);
      repeat (6) @(negedge clk);
      chk("pre_rst_hs", int'(hs_out), 1);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rom_addr", int'(rom_addr), 0);
      chk("midrst_pix", int'(pix_on), 0);
      chk("midrst_hs", int'(hs_out), 0);
      chk("midrst_de", int'(de_out), 0);
      chk("midrst_busy", int'(busy), 1);
      chk("midrst_ack", int'(wr_ack), 0);
      hs_in = 1'b0; de_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      busy_len("rst_busy_len");

      // every cell must read back 0x00
      any_nz = 1'b0; de_in = 1'b1;
      for (int c = 0; c < CELLS; c++) begin
         hcount = HW'(X0 + (c % COLS) * 8 + 2);
         vcount = HW'(Y0 + (c / COLS) * 8 + 1);
         @(negedge clk);
         any_nz |= (rom_addr != 8'h00);
      end
      de_in = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any_nz |= (rom_addr != 8'h00);
      end
      chk("post_rst_cells", int'(any_nz), 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
